// File: rtl/audio_event_sequencer_if.sv
// Event/request bundle between game logic, the audio event sequencer and the tone generator.
// The master drives game events and mute; the slave (sequencer) returns requests and status.
interface audio_event_sequencer_if #(
    parameter int DEPTH = 4
) ();
    logic                     ev_miss;
    logic                     ev_bounce;
    logic                     ev_hit;
    logic                     mute;
    logic [1:0]               snd_sel;
    logic                     busy;
    logic                     drop;
    logic [$clog2(DEPTH):0]   level;

    modport master (
        output ev_miss, ev_bounce, ev_hit, mute,
        input  snd_sel, busy, drop, level
    );

    modport slave (
        input  ev_miss, ev_bounce, ev_hit, mute,
        output snd_sel, busy, drop, level
    );
endinterface

// File: rtl/audio_event_sequencer.sv
// Queues single-cycle game sound events and issues them to the tone generator one at a time,
// holding off for each sound's play time (plus a fixed gap) before issuing the next.
module audio_event_sequencer #(
    parameter int TICKS_PER_MS = 16000,
    parameter int DEPTH        = 4,
    parameter int DUR_MISS     = 80,
    parameter int DUR_BOUNCE   = 60,
    parameter int DUR_HIT      = 70,
    parameter int GAP_MS       = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    audio_event_sequencer_if.slave     bus
);
    localparam int PS_W  = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [1:0] CODE_MISS   = 2'd1;
    localparam logic [1:0] CODE_BOUNCE = 2'd2;
    localparam logic [1:0] CODE_HIT    = 2'd3;

    localparam logic [7:0] WAIT_MISS   = 8'(DUR_MISS + GAP_MS);
    localparam logic [7:0] WAIT_BOUNCE = 8'(DUR_BOUNCE + GAP_MS);
    localparam logic [7:0] WAIT_HIT    = 8'(DUR_HIT + GAP_MS);

    generate
        if ((DUR_MISS + GAP_MS > 255) || (DUR_BOUNCE + GAP_MS > 255) || (DUR_HIT + GAP_MS > 255) ||
            (DUR_MISS + GAP_MS < 1) || (DUR_BOUNCE + GAP_MS < 1) || (DUR_HIT + GAP_MS < 1)) begin : g_bad_dur
            $error("audio_event_sequencer: hold-off must be 1..255 ms to fit the 8-bit wait counter");
        end
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("audio_event_sequencer: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [1:0]       r_fifo [DEPTH];
    logic [CNT_W-1:0] r_wr_cnt;
    logic [CNT_W-1:0] r_rd_cnt;
    logic [7:0]       r_wait;
    logic [PS_W-1:0]  r_presc;
    logic             r_drop;

    logic [1:0]       w_head;
    logic [CNT_W-1:0] w_level;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_any_ev;
    logic [1:0]       w_ev_cnt;
    logic             w_push;
    logic             w_drop_nxt;
    logic [1:0]       w_code;
    logic [7:0]       w_wait_load;

    assign w_head   = r_fifo[r_rd_cnt[PTR_W-1:0]];
    assign w_level  = r_wr_cnt - r_rd_cnt;
    assign w_empty  = (w_level == '0);
    assign w_full   = (w_level == CNT_W'(DEPTH));
    assign w_pop    = (r_state == ST_ISSUE) && !bus.mute;
    assign w_any_ev = bus.ev_miss | bus.ev_bounce | bus.ev_hit;
    assign w_ev_cnt = {1'b0, bus.ev_miss} + {1'b0, bus.ev_bounce} + {1'b0, bus.ev_hit};

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_push     = !bus.mute && w_any_ev && (!w_full || w_pop);
    assign w_drop_nxt = !bus.mute && ((w_ev_cnt > 2'd1) || (w_any_ev && w_full && !w_pop));

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_code = CODE_BOUNCE;
        if (bus.ev_miss) begin
            w_code = CODE_MISS;
        end else if (bus.ev_hit) begin
            w_code = CODE_HIT;
        end
    end

    always_comb begin
        w_wait_load = WAIT_BOUNCE;
        case (w_head)
            CODE_MISS: w_wait_load = WAIT_MISS;
            CODE_HIT:  w_wait_load = WAIT_HIT;
            default:   w_wait_load = WAIT_BOUNCE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_wait   <= '0;
            r_presc  <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_drop <= w_drop_nxt;

            if (bus.mute) begin
                r_rd_cnt <= r_wr_cnt;
            end else begin
                if (w_push) r_wr_cnt <= r_wr_cnt + 1'b1;
                if (w_pop)  r_rd_cnt <= r_rd_cnt + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!w_empty && !bus.mute) r_state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    // A muted issue plays nothing, so there is nothing to wait out.
                    if (bus.mute) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait  <= w_wait_load;
                        r_presc <= '0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_presc == PS_W'(TICKS_PER_MS - 1)) begin
                        r_presc <= '0;
                        r_wait  <= r_wait - 8'd1;
                        if (r_wait == 8'd1) r_state <= ST_IDLE;
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_cnt[PTR_W-1:0]] <= w_code;
    end

    assign bus.snd_sel = (w_pop && rst_n) ? w_head : 2'd0;
    assign bus.busy    = (r_state != ST_IDLE) || !w_empty;
    assign bus.drop    = r_drop;
    assign bus.level   = w_level;
endmodule

// File: tb/tb_audio_event_sequencer.sv
// Directed bench for audio_event_sequencer with scaled-down timing: 4 clks/ms, durations 5/3/4 ms, 1 ms gap.
// Hold-offs: miss 24 clks, bounce 16 clks, hit 20 clks; back-to-back spacing is hold-off + 2.
module tb_audio_event_sequencer;
    localparam int TPM = 4;
    localparam int W_BOUNCE = (3 + 1) * TPM;
    localparam int W_HIT    = (4 + 1) * TPM;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    audio_event_sequencer_if #(.DEPTH(4)) bus ();

    audio_event_sequencer #(
        .TICKS_PER_MS(TPM), .DEPTH(4), .DUR_MISS(5), .DUR_BOUNCE(3), .DUR_HIT(4), .GAP_MS(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Steps until snd_sel is non-zero; at=-1 when the cycle budget runs out.
    task automatic wait_pulse(output int at, output logic [1:0] code);
        at = -1;
        code = 2'd0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (bus.snd_sel != 2'd0) begin
                at = cyc;
                code = bus.snd_sel;
                return;
            end
        end
    endtask

    // Steps until busy falls; counts snd_sel pulses seen on the way. at=-1 on timeout.
    task automatic wait_idle(output int at, output int pulses);
        at = -1;
        pulses = 0;
        for (int k = 0; k < 400; k++) begin
            step();
            if (bus.snd_sel != 2'd0) pulses++;
            if (!bus.busy) begin
                at = cyc;
                return;
            end
        end
    endtask

    initial begin
        int at;
        int pulses;
        int cnt;
        int p_prev;
        logic [1:0] code;

        bus.ev_miss = 1'b0;
        bus.ev_bounce = 1'b0;
        bus.ev_hit = 1'b0;
        bus.mute = 1'b0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_snd_sel", bus.snd_sel, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_drop", bus.drop, 0);
        check("rst_level", bus.level, 0);
        rst_n = 1'b1;
        step();

        // 1: single hit from idle -> code 3 two clks later, busy for hold-off + 2 clks
        bus.ev_hit = 1'b1;
        step();
        bus.ev_hit = 1'b0;
        check("t1_level_n1", bus.level, 1);
        check("t1_sel_n1", bus.snd_sel, 0);
        check("t1_busy_n1", bus.busy, 1);
        step();
        check("t1_sel_n2", bus.snd_sel, 3);
        check("t1_level_n2", bus.level, 1);
        cnt = 2;
        pulses = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (!bus.busy) break;
            if (bus.snd_sel != 2'd0) pulses++;
            cnt++;
        end
        check("t1_busy_len", cnt, W_HIT + 2);
        check("t1_extra_pulses", pulses, 0);
        check("t1_level_end", bus.level, 0);

        // 2: miss+bounce together -> only code 1 queued, one drop pulse
        bus.ev_miss = 1'b1;
        bus.ev_bounce = 1'b1;
        step();
        bus.ev_miss = 1'b0;
        bus.ev_bounce = 1'b0;
        check("t2_drop", bus.drop, 1);
        check("t2_level", bus.level, 1);
        step();
        check("t2_drop_clr", bus.drop, 0);
        check("t2_sel", bus.snd_sel, 1);
        wait_idle(at, pulses);
        check("t2_no_bounce", pulses, 0);
        check("t2_idle_timeout", (at >= 0), 1);
        check("t2_level_end", bus.level, 0);

        // 3: six bounce pulses on consecutive clks -> 1 issued, 4 queued, 1 drop
        p_prev = -1;
        for (int i = 0; i < 6; i++) begin
            bus.ev_bounce = 1'b1;
            step();
            check("t3_drop", bus.drop, (i == 5));
            if (i == 1) begin
                check("t3_first_sel", bus.snd_sel, 2);
                p_prev = cyc;
            end
        end
        bus.ev_bounce = 1'b0;
        check("t3_level_full", bus.level, 4);
        for (int n = 0; n < 4; n++) begin
            wait_pulse(at, code);
            check("t3_code", code, 2);
            check("t3_gap", at - p_prev, W_BOUNCE + 2);
            p_prev = at;
        end
        step();
        check("t3_level_drained", bus.level, 0);
        wait_idle(at, pulses);
        check("t3_no_sixth", pulses, 0);
        check("t3_idle_timeout", (at >= 0), 1);

        // 4: FIFO full, event arrives during ISSUE -> accepted, level stays 4, no drop
        for (int i = 0; i < 5; i++) begin
            bus.ev_hit = 1'b1;
            step();
            if (i == 1) p_prev = cyc;
        end
        bus.ev_hit = 1'b0;
        check("t4_level_full", bus.level, 4);
        wait_pulse(at, code);
        check("t4_code", code, 3);
        check("t4_gap", at - p_prev, W_HIT + 2);
        check("t4_level_at_issue", bus.level, 4);
        bus.ev_miss = 1'b1;
        step();
        bus.ev_miss = 1'b0;
        check("t4_level_after", bus.level, 4);
        check("t4_no_drop", bus.drop, 0);

        // 5: mute mid-WAIT with 3 queued -> flush, no pulses, busy falls at end of WAIT
        wait_pulse(at, code);
        check("t5_code", code, 3);
        p_prev = at;
        repeat (3) step();
        check("t5_level_before", bus.level, 3);
        bus.mute = 1'b1;
        step();
        check("t5_level_flushed", bus.level, 0);
        check("t5_busy_wait", bus.busy, 1);
        bus.ev_hit = 1'b1;
        step();
        bus.ev_hit = 1'b0;
        check("t5_muted_drop", bus.drop, 0);
        check("t5_muted_level", bus.level, 0);
        wait_idle(at, pulses);
        check("t5_no_pulses", pulses, 0);
        check("t5_busy_fall", at - p_prev, W_HIT + 1);
        bus.mute = 1'b0;
        repeat (3) step();
        check("t5_idle_sel", bus.snd_sel, 0);
        check("t5_idle_busy", bus.busy, 0);
        check("t5_idle_level", bus.level, 0);

        // 6: reset pulse mid-WAIT with 2 queued, then a fresh hit
        for (int i = 0; i < 3; i++) begin
            bus.ev_bounce = 1'b1;
            step();
            if (i == 1) check("t6_first_sel", bus.snd_sel, 2);
        end
        bus.ev_bounce = 1'b0;
        repeat (2) step();
        check("t6_level_before", bus.level, 2);
        check("t6_busy_before", bus.busy, 1);
        rst_n = 1'b0;
        step();
        check("t6_rst_sel", bus.snd_sel, 0);
        check("t6_rst_level", bus.level, 0);
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_drop", bus.drop, 0);
        rst_n = 1'b1;
        bus.ev_hit = 1'b1;
        step();
        bus.ev_hit = 1'b0;
        check("t6_level_new", bus.level, 1);
        check("t6_sel_early", bus.snd_sel, 0);
        step();
        check("t6_sel_hit", bus.snd_sel, 3);
        wait_idle(at, pulses);
        check("t6_no_residual", pulses, 0);
        check("t6_idle_timeout", (at >= 0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
